vga_sync_receiver: RTL
======================

VGA_SYNC_RECEIVER -- requirements
Module: vga_sync_receiver

Interface
REQ-001 H_TOTAL, 800, expected clocks per line.
REQ-002 V_TOTAL, 525, expected lines per frame.
REQ-003 H_ACT_START, 144, hcnt of the first active pixel; H_ACT, 640, active pixels per line.
REQ-004 V_ACT_START, 35, vcnt of the first active line; V_ACT, 480, active lines per frame.
REQ-005 clk  in  1  pixel clock; one clock, all logic on the rising edge.
REQ-006 clr  in  1  reset, synchronous, active-high.
REQ-007 hsync_i, vsync_i  in  1 each  sync inputs, active-low pulses, same clock domain as clk.
REQ-008 r_i, g_i, b_i  in  4 each  pixel colour.
REQ-009 locked  out  1  timing verified.
REQ-010 frame_start  out  1  one-cycle pulse at each frame start while locked.
REQ-011 pix_valid  out  1  pix_x/pix_y/pix_rgb describe an active pixel.
REQ-012 pix_x, pix_y  out  10 each  active-area coordinates, origin top-left.
REQ-013 pix_rgb  out  12  {r,g,b} of the pixel.
REQ-014 sync_err  out  1  one-cycle pulse on a timing violation.
REQ-015 line_len  out  10  clocks in the last complete line.

Function
REQ-016 Inputs registered twice (d1, d2); hfall = d2 & ~d1 on hsync; vfall likewise on vsync; RGB delayed to match d1.
REQ-017 hcnt: 0 on the hfall cycle, +1 per clock otherwise, saturating at 1023.
REQ-018 At hfall: line_len <= hcnt+1 (truncated to 10 bits); vcnt <= 0 if vfall in the same cycle, else vcnt+1 saturating at 1023.
REQ-019 vfall without a simultaneous hfall: vcnt <= 0; hcnt is unaffected.
REQ-020 FSM states: SEARCH, CHECK, LOCKED.
REQ-021 SEARCH: on vfall -> CHECK.
REQ-022 CHECK: on hfall, if hcnt+1 != H_TOTAL, set the bad flag.
REQ-023 CHECK: on vfall, -> LOCKED if the bad flag is clear and the line count equals V_TOTAL; else stay in CHECK. The bad flag clears at every vfall.
REQ-024 The first vfall after SEARCH only starts the count; it is not itself checked.
REQ-025 LOCKED: line-length mismatch at hfall, frame line-count mismatch at vfall, or hcnt reaching 1023 -> SEARCH with a sync_err pulse.
REQ-026 CHECK: hcnt reaching 1023 -> SEARCH with no sync_err pulse.
REQ-027 locked = 1 only in LOCKED.
REQ-028 frame_start pulses on the vfall cycle while in LOCKED and remaining in LOCKED.
REQ-029 pix_valid = LOCKED && H_ACT_START <= hcnt < H_ACT_START+H_ACT && V_ACT_START <= vcnt < V_ACT_START+V_ACT.
REQ-030 pix_x = hcnt - H_ACT_START and pix_y = vcnt - V_ACT_START; pix_x, pix_y and pix_rgb are registered together with pix_valid.
REQ-031 Latency: an RGB sample at input cycle n appears on pix_rgb at cycle n+3.
REQ-032 When pix_valid = 0: pix_x = 0, pix_y = 0, pix_rgb = 0.

Reset
REQ-033 clr forces state SEARCH; hcnt, vcnt and the bad flag = 0; sync registers = 1; all outputs = 0.
REQ-034 clr mid-frame: outputs are 0 on the next cycle, and locking requires a fresh SEARCH -> CHECK -> LOCKED sequence.

Configuration
REQ-035 Macro VGA_RX_CHECKSUM_EN defined: add output frame_sum [15:0]; the internal accumulator adds pix_rgb (zero-extended) on each pix_valid cycle, modulo 2^16.
REQ-036 With the macro: on each frame_start, frame_sum <= accumulator (including any pixel valid in that same cycle), and the accumulator clears. Reset value of both is 0.
REQ-037 Macro undefined: no frame_sum port and no accumulator logic; all other behaviour is identical.

Verification
REQ-038 Nominal 800x525 timing (hsync low 96 clocks, vsync low 2 lines), constant RGB 0xFFF -> locked rises at the third vfall; 307200 pix_valid cycles per frame; line_len = 800.
REQ-039 Locked, then one line of 801 clocks -> single sync_err pulse at that hfall; locked = 0; relock after two further clean frames.
REQ-040 Locked, then a frame of 524 lines -> sync_err pulse and locked = 0 at the early vfall.
REQ-041 hsync held high for 1100 clocks while locked -> sync_err pulse when hcnt reaches 1023; state SEARCH; pix_valid stays 0.
REQ-042 Active-window corners: pixel (0,0) = 0x123 and (639,479) = 0xABC -> these values appear on pix_rgb 3 cycles after input, with matching pix_x/pix_y.
REQ-043 Checksum (VGA_RX_CHECKSUM_EN defined), every active pixel = 0x001 -> frame_sum = 307200 mod 65536 = 45056 after each frame_start.

Source files
------------

// File: rtl/vga_sync_receiver.sv
// VGA timing receiver: locks onto hsync/vsync, verifies line and frame lengths, emits active-area pixels.
// Optional build macro VGA_RX_CHECKSUM_EN adds a per-frame pixel checksum output (frame_sum).
`timescale 1ns/1ps
module vga_sync_receiver #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_ACT_START = 144,
  parameter int H_ACT       = 640,
  parameter int V_ACT_START = 35,
  parameter int V_ACT       = 480
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic [3:0]  r_i,
  input  logic [3:0]  g_i,
  input  logic [3:0]  b_i,
  output logic        locked,
  output logic        frame_start,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [11:0] pix_rgb,
  output logic        sync_err,
  output logic [9:0]  line_len
`ifdef VGA_RX_CHECKSUM_EN
  ,
  output logic [15:0] frame_sum
`endif
);

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

  localparam logic [10:0] H_TOTAL_W = 11'(H_TOTAL);
  localparam logic [10:0] V_TOTAL_W = 11'(V_TOTAL);
  localparam logic [10:0] H_LO      = 11'(H_ACT_START);
  localparam logic [10:0] H_HI      = 11'(H_ACT_START + H_ACT);
  localparam logic [10:0] V_LO      = 11'(V_ACT_START);
  localparam logic [10:0] V_HI      = 11'(V_ACT_START + V_ACT);
  localparam logic [9:0]  CNT_MAX   = 10'd1023;

  state_t      state_q, state_d;
  logic        hs_d1_q, hs_d2_q, vs_d1_q, vs_d2_q;
  logic [11:0] rgb_d1_q, rgb_d2_q;
  logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [9:0]  line_len_q, line_len_d;
  logic        bad_q, bad_d, armed_q, armed_d;
  logic        frame_start_q, frame_start_d, sync_err_q, sync_err_d;
  logic        pix_valid_q, pix_valid_d;
  logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [11:0] pix_rgb_q, pix_rgb_d;
  logic        hfall, vfall, h_bad, v_bad, hcnt_max;
  logic [10:0] hcnt_p1, vcnt_p1;

  always_comb begin
    hfall    = hs_d2_q & ~hs_d1_q;
    vfall    = vs_d2_q & ~vs_d1_q;
    hcnt_p1  = {1'b0, hcnt_q} + 11'd1;
    vcnt_p1  = {1'b0, vcnt_q} + 11'd1;
    hcnt_max = (hcnt_q == CNT_MAX);
    h_bad    = hfall && (hcnt_p1 != H_TOTAL_W);
    v_bad    = (vcnt_p1 != V_TOTAL_W);

    hcnt_d     = hfall ? 10'd0 : (hcnt_max ? hcnt_q : hcnt_p1[9:0]);
    vcnt_d     = vcnt_q;
    line_len_d = line_len_q;
    if (hfall) begin
      line_len_d = hcnt_p1[9:0];
      vcnt_d     = vfall ? 10'd0 : ((vcnt_q == CNT_MAX) ? vcnt_q : vcnt_p1[9:0]);
    end else if (vfall) begin
      vcnt_d = 10'd0;
    end
  end

  // The first vfall seen in CHECK only arms the frame count; later ones are judged.
  always_comb begin
    state_d       = state_q;
    bad_d         = bad_q;
    armed_d       = armed_q;
    frame_start_d = 1'b0;
    sync_err_d    = 1'b0;
    case (state_q)
      SEARCH: begin
        bad_d   = 1'b0;
        armed_d = 1'b0;
        if (vfall) state_d = CHECK;
      end
      CHECK: begin
        if (h_bad) bad_d = 1'b1;
        if (vfall) begin
          if (armed_q && !(bad_q || h_bad) && !v_bad) state_d = LOCKED;
          armed_d = 1'b1;
          bad_d   = 1'b0;
        end
        if (hcnt_max) state_d = SEARCH;
      end
      LOCKED: begin
        bad_d   = 1'b0;
        armed_d = 1'b0;
        if (h_bad || (vfall && v_bad) || hcnt_max) begin
          state_d    = SEARCH;
          sync_err_d = 1'b1;
        end else if (vfall) begin
          frame_start_d = 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_comb begin
    pix_valid_d = (state_q == LOCKED)
               && ({1'b0, hcnt_q} >= H_LO) && ({1'b0, hcnt_q} < H_HI)
               && ({1'b0, vcnt_q} >= V_LO) && ({1'b0, vcnt_q} < V_HI);
    pix_x_d     = pix_valid_d ? (hcnt_q - H_LO[9:0]) : 10'd0;
    pix_y_d     = pix_valid_d ? (vcnt_q - V_LO[9:0]) : 10'd0;
    pix_rgb_d   = pix_valid_d ? rgb_d2_q : 12'd0;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q       <= SEARCH;
      hs_d1_q       <= 1'b1;
      hs_d2_q       <= 1'b1;
      vs_d1_q       <= 1'b1;
      vs_d2_q       <= 1'b1;
      rgb_d1_q      <= 12'd0;
      rgb_d2_q      <= 12'd0;
      hcnt_q        <= 10'd0;
      vcnt_q        <= 10'd0;
      line_len_q    <= 10'd0;
      bad_q         <= 1'b0;
      armed_q       <= 1'b0;
      frame_start_q <= 1'b0;
      sync_err_q    <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= 10'd0;
      pix_y_q       <= 10'd0;
      pix_rgb_q     <= 12'd0;
    end else begin
      state_q       <= state_d;
      hs_d1_q       <= hsync_i;
      hs_d2_q       <= hs_d1_q;
      vs_d1_q       <= vsync_i;
      vs_d2_q       <= vs_d1_q;
      rgb_d1_q      <= {r_i, g_i, b_i};
      rgb_d2_q      <= rgb_d1_q;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      line_len_q    <= line_len_d;
      bad_q         <= bad_d;
      armed_q       <= armed_d;
      frame_start_q <= frame_start_d;
      sync_err_q    <= sync_err_d;
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_rgb_q     <= pix_rgb_d;
    end
  end

  assign locked      = (state_q == LOCKED);
  assign frame_start = frame_start_q;
  assign sync_err    = sync_err_q;
  assign line_len    = line_len_q;
  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_rgb     = pix_rgb_q;

`ifdef VGA_RX_CHECKSUM_EN
  // A pixel landing on the frame_start cycle belongs to the frame being closed.
  logic [15:0] acc_q, acc_d, frame_sum_q, frame_sum_d, acc_add;

  always_comb begin
    acc_add     = acc_q + (pix_valid_q ? {4'd0, pix_rgb_q} : 16'd0);
    acc_d       = acc_add;
    frame_sum_d = frame_sum_q;
    if (frame_start_q) begin
      frame_sum_d = acc_add;
      acc_d       = 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      acc_q       <= 16'd0;
      frame_sum_q <= 16'd0;
    end else begin
      acc_q       <= acc_d;
      frame_sum_q <= frame_sum_d;
    end
  end

  assign frame_sum = frame_sum_q;
`endif

endmodule
